// File: rtl/receptor_morse.sv
// Morse receiver: times marks/gaps of a keyed line and decodes dot/dash groups to ASCII.
// Latency: 2-cycle input sync; char strobe 1 cycle after the 2*UNIDAD-th gap cycle, space after the 5*UNIDAD-th.
// Backpressure: none; every valido strobe must be consumed by downstream logic.
module receptor_morse #(
  parameter int unsigned UNIDAD     = 5_000_000,
  parameter int unsigned ANCHO_CONT = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       linea,
  output logic [7:0] caracter,
  output logic       valido,
  output logic       error
);

  localparam logic [ANCHO_CONT-1:0] UMBRAL_RAYA = ANCHO_CONT'(2 * UNIDAD);
  localparam logic [ANCHO_CONT-1:0] UMBRAL_PAL  = ANCHO_CONT'(5 * UNIDAD);
  localparam logic [ANCHO_CONT-1:0] CONT_MAX    = '1;

  typedef enum logic [1:0] {REPOSO, MARCA, HUECO, FIN_LETRA} estado_t;

  logic                  sinc1_q, sinc2_q, linea_s;
  logic                  nivel_q;
  logic [ANCHO_CONT-1:0] cont_q, run;
  estado_t               estado_q, estado_d;
  logic [4:0]            patron_q, patron_d;
  logic [2:0]            n_q, n_d;
  logic                  desb_q, desb_d;
  logic                  emite_car, emite_esp;
  logic [7:0]            letra, cod;
  logic                  cod_err;
  logic [7:0]            caracter_q;
  logic                  valido_q, error_q;

  assign linea_s = sinc2_q;

  // Two-flop synchronizer for the asynchronous keyed line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sinc1_q <= 1'b0;
      sinc2_q <= 1'b0;
    end else begin
      sinc1_q <= linea;
      sinc2_q <= sinc1_q;
    end
  end

  // Length of the current run including this cycle; restarts at 1 on a level change, saturates.
  always_comb begin
    if (linea_s != nivel_q)   run = ANCHO_CONT'(1);
    else if (cont_q == CONT_MAX) run = cont_q;
    else                      run = cont_q + ANCHO_CONT'(1);
  end

  // Run-length counter; cont_q holds the number of completed cycles at level nivel_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nivel_q <= 1'b0;
      cont_q  <= '0;
    end else begin
      nivel_q <= linea_s;
      cont_q  <= run;
    end
  end

  // Next-state logic: element classification, element accumulation and emission triggers.
  always_comb begin
    estado_d  = estado_q;
    patron_d  = patron_q;
    n_d       = n_q;
    desb_d    = desb_q;
    emite_car = 1'b0;
    emite_esp = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (linea_s) estado_d = MARCA;
      end
      MARCA: begin
        // cont_q is the full mark length when the first low cycle shows up.
        if (!linea_s) begin
          if (n_q < 3'd5) begin
            patron_d = {patron_q[3:0], (cont_q >= UMBRAL_RAYA)};
            n_d      = n_q + 3'd1;
          end else begin
            desb_d = 1'b1;
          end
          estado_d = HUECO;
        end
      end
      HUECO: begin
        if (!linea_s && run == UMBRAL_RAYA) begin
          emite_car = 1'b1;
          patron_d  = '0;
          n_d       = '0;
          desb_d    = 1'b0;
          estado_d  = FIN_LETRA;
        end else if (linea_s) begin
          estado_d = MARCA;
        end
      end
      FIN_LETRA: begin
        if (!linea_s && run == UMBRAL_PAL) begin
          emite_esp = 1'b1;
          estado_d  = REPOSO;
        end else if (linea_s) begin
          estado_d = MARCA;
        end
      end
      default: estado_d = REPOSO;
    endcase
  end

  // State and element registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= REPOSO;
      patron_q <= '0;
      n_q      <= '0;
      desb_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      patron_q <= patron_d;
      n_q      <= n_d;
      desb_q   <= desb_d;
    end
  end

  // ITU decode table; letra stays 0 for unassigned patterns, which then become '?'.
  always_comb begin
    letra = 8'h00;
    case (n_q)
      3'd1: letra = patron_q[0] ? "T" : "E";
      3'd2: case (patron_q[1:0])
              2'b00: letra = "I";
              2'b01: letra = "A";
              2'b10: letra = "N";
              2'b11: letra = "M";
            endcase
      3'd3: case (patron_q[2:0])
              3'b000: letra = "S";
              3'b001: letra = "U";
              3'b010: letra = "R";
              3'b011: letra = "W";
              3'b100: letra = "D";
              3'b101: letra = "K";
              3'b110: letra = "G";
              3'b111: letra = "O";
            endcase
      3'd4: case (patron_q[3:0])
              4'b0000: letra = "H";
              4'b0001: letra = "V";
              4'b0010: letra = "F";
              4'b0100: letra = "L";
              4'b0110: letra = "P";
              4'b0111: letra = "J";
              4'b1000: letra = "B";
              4'b1001: letra = "X";
              4'b1010: letra = "C";
              4'b1011: letra = "Y";
              4'b1100: letra = "Z";
              4'b1101: letra = "Q";
              default: letra = 8'h00;
            endcase
      3'd5: case (patron_q)
              5'b01111: letra = "1";
              5'b00111: letra = "2";
              5'b00011: letra = "3";
              5'b00001: letra = "4";
              5'b00000: letra = "5";
              5'b10000: letra = "6";
              5'b11000: letra = "7";
              5'b11100: letra = "8";
              5'b11110: letra = "9";
              5'b11111: letra = "0";
              default:  letra = 8'h00;
            endcase
      default: letra = 8'h00;
    endcase
    cod     = 8'h3F;
    cod_err = 1'b1;
    if (!desb_q && letra != 8'h00) begin
      cod     = letra;
      cod_err = 1'b0;
    end
  end

  // Registered outputs: caracter holds between emissions, error only accompanies a strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      caracter_q <= 8'h00;
      valido_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      valido_q <= emite_car | emite_esp;
      error_q  <= 1'b0;
      if (emite_car) begin
        caracter_q <= cod;
        error_q    <= cod_err;
      end else if (emite_esp) begin
        caracter_q <= 8'h20;
      end
    end
  end

  assign caracter = caracter_q;
  assign valido   = valido_q;
  assign error    = error_q;

endmodule

// File: tb/tb_receptor_morse.sv
// Directed bench for receptor_morse with UNIDAD = 4.
// Emissions are captured on the falling edge with their cycle stamp and compared to hand-derived values.
// Latency reference: character = gap start + 2*UNIDAD + 2 sync cycles, space = gap start + 5*UNIDAD + 2.
module tb_receptor_morse;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       linea;
  logic [7:0] caracter;
  logic       valido;
  logic       error;

  receptor_morse #(.UNIDAD(4), .ANCHO_CONT(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .linea    (linea),
    .caracter (caracter),
    .valido   (valido),
    .error    (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_ini = 0;
  int t0;
  int consec = 0;
  logic valido_prev = 1'b0;
  int em_car[$];
  int em_err[$];
  int em_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every strobe and flag back-to-back strobes.
  always @(negedge clk) begin
    if (valido) begin
      em_car.push_back(int'(caracter));
      em_err.push_back(int'(error));
      em_cyc.push_back(cyc);
      if (valido_prev) consec++;
    end
    valido_prev = valido;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare emission idx; dly > 0 also checks its cycle distance from t_ref.
  task automatic check_em(input string tag, input int idx, input int car, input int err,
                          input int dly, input int t_ref);
    if (idx < em_car.size()) begin
      check_eq({tag, "_char"}, em_car[idx], car);
      check_eq({tag, "_err"}, em_err[idx], err);
      if (dly > 0) check_eq({tag, "_lat"}, em_cyc[idx] - t_ref, dly);
    end else begin
      check_eq({tag, "_count"}, em_car.size(), idx + 1);
    end
  endtask

  task automatic limpiar();
    em_car.delete();
    em_err.delete();
    em_cyc.delete();
  endtask

  task automatic tono(input int k);
    linea = 1'b1;
    repeat (k) @(negedge clk);
  endtask

  task automatic silencio(input int k);
    t_ini = cyc;
    linea = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic puntos(input int k);
    for (int i = 0; i < k; i++) begin
      tono(4);
      if (i < k - 1) silencio(4);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    linea = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_caracter", int'(caracter), 8'h00);
    check_eq("rst_valido", int'(valido), 0);
    check_eq("rst_error", int'(error), 0);
    rst_n = 1'b1;
    silencio(30);
    check_eq("idle_no_emit", em_car.size(), 0);

    // Single dot: 'E' at gap+10, nothing else until the space at gap+22.
    limpiar();
    tono(4);
    silencio(19);
    t0 = t_ini;
    check_eq("E_only_before_space", em_car.size(), 1);
    check_em("E", 0, 8'h45, 0, 10, t0);
    silencio(11);
    check_em("E_space", 1, 8'h20, 0, 22, t0);

    // Letter A.
    limpiar();
    tono(4); silencio(4); tono(12); silencio(30);
    check_eq("A_count", em_car.size(), 2);
    check_em("A", 0, 8'h41, 0, 10, t_ini);
    check_em("A_space", 1, 8'h20, 0, 22, t_ini);

    // Dot/dash boundary: 7 cycles is a dot, 8 a dash.
    limpiar();
    tono(7); silencio(30);
    check_em("mark7", 0, 8'h45, 0, 0, 0);
    limpiar();
    tono(8); silencio(30);
    check_em("mark8", 0, 8'h54, 0, 0, 0);

    // Gap of 7 keeps the same character.
    limpiar();
    tono(4); silencio(7); tono(4); silencio(30);
    check_eq("gap7_count", em_car.size(), 2);
    check_em("gap7", 0, 8'h49, 0, 0, 0);

    // Five dots, six dots, unassigned ..--
    limpiar();
    puntos(5); silencio(30);
    check_em("five", 0, 8'h35, 0, 0, 0);
    limpiar();
    puntos(6); silencio(30);
    check_em("six", 0, 8'h3F, 1, 0, 0);
    check_em("six_space", 1, 8'h20, 0, 0, 0);
    limpiar();
    tono(4); silencio(4); tono(4); silencio(4); tono(12); silencio(4); tono(12); silencio(30);
    check_em("unassigned", 0, 8'h3F, 1, 0, 0);

    // Back-to-back S and O with a 12-cycle gap: no space between them.
    limpiar();
    puntos(3); silencio(12);
    tono(12); silencio(4); tono(12); silencio(4); tono(12); silencio(30);
    check_eq("SO_count", em_car.size(), 3);
    check_em("SO_S", 0, 8'h53, 0, 0, 0);
    check_em("SO_O", 1, 8'h4F, 0, 0, 0);
    check_em("SO_space", 2, 8'h20, 0, 0, 0);

    // Reset during the second element of 'A'; caracter holds 0x20 beforehand.
    tono(4); silencio(4); tono(6);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_caracter", int'(caracter), 8'h00);
    check_eq("midrst_valido", int'(valido), 0);
    check_eq("midrst_error", int'(error), 0);
    linea = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    limpiar();
    silencio(10);
    tono(8); silencio(15);
    check_eq("post_rst_count", em_car.size(), 1);
    check_em("post_rst_T", 0, 8'h54, 0, 10, t_ini);
    silencio(15);

    check_eq("strobe_consecutive", consec, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
